// File: rtl/sort_ctrl_2bit.sv
// sort_ctrl_2bit: bubble-sort sequencer for DEPTH 2-bit values using a shared external comparator.
//   in_valid/in_ready/in_data    : operand load stream (LOAD state)
//   out_valid/out_ready/out_data : sorted drain stream, smallest first (DRAIN state)
//   cmp_a/cmp_b/cmp_y            : shared comparator, cmp_y one-hot 001 eq, 010 lt, 100 gt
//   busy                         : high in SORT; cmp_err sticky on illegal cmp_y during SORT
//   SORT_EARLY_EXIT_EN           : when defined, a pass with no swaps ends the sort early
module sort_ctrl_2bit #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [1:0] in_data,
  output logic       in_ready,
  output logic       out_valid,
  output logic [1:0] out_data,
  input  logic       out_ready,
  output logic [1:0] cmp_a,
  output logic [1:0] cmp_b,
  input  logic [2:0] cmp_y,
  output logic       busy,
  output logic       cmp_err
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  localparam logic [PW-1:0] IEND = PW'(DEPTH - 2);
  localparam logic [PW-1:0] ONE = PW'(1);
  typedef enum logic [1:0] {LOAD, SORT, DRAIN} state_t;
  state_t state, state_n;
  logic [DEPTH-1:0][1:0] mem;
  logic [PW-1:0] load_ptr, drain_ptr, pass, idx, nxt;
  logic in_fire, out_fire, swap, bad, pass_end, sort_done;
`ifdef SORT_EARLY_EXIT_EN
  logic swapped, pass_swap;
  // swap history restarts at idx 0 so each pass is judged on its own compares
  assign pass_swap = (idx == '0 ? 1'b0 : swapped) | swap;
  assign sort_done = pass_end && (pass == IEND || !pass_swap);
  always_ff @(posedge clk)
    swapped <= rst ? 1'b0 : busy ? pass_swap : swapped;
`else
  assign sort_done = pass_end && pass == IEND;
`endif
  always_comb begin
    in_ready  = state == LOAD;
    out_valid = state == DRAIN;
    busy      = state == SORT;
    nxt       = idx + ONE;
    cmp_a     = busy ? mem[idx] : 2'd0;
    cmp_b     = busy ? mem[nxt] : 2'd0;
    out_data  = out_valid ? mem[drain_ptr] : 2'd0;
    in_fire   = in_valid && in_ready;
    out_fire  = out_valid && out_ready;
    swap      = busy && cmp_y == 3'b100;
    bad       = busy && !(cmp_y == 3'b001 || cmp_y == 3'b010 || cmp_y == 3'b100);
    pass_end  = idx == IEND;
    state_n   = (state == LOAD && in_fire && load_ptr == LAST) ? SORT :
                (state == SORT && sort_done) ? DRAIN :
                (state == DRAIN && out_fire && drain_ptr == LAST) ? LOAD : state;
  end
  always_ff @(posedge clk)
    state <= rst ? LOAD : state_n;
  always_ff @(posedge clk) begin
    if (rst) begin
      mem       <= '0;
      load_ptr  <= '0;
      drain_ptr <= '0;
      pass      <= '0;
      idx       <= '0;
      cmp_err   <= 1'b0;
    end else begin
      if (in_fire) begin
        mem[load_ptr] <= in_data;
        load_ptr      <= load_ptr == LAST ? '0 : load_ptr + ONE;
      end
      if (swap) begin
        mem[idx] <= mem[nxt];
        mem[nxt] <= mem[idx];
      end
      if (bad)
        cmp_err <= 1'b1;
      if (busy) begin
        idx  <= pass_end ? '0 : nxt;
        pass <= !pass_end ? pass : sort_done ? '0 : pass + ONE;
      end
      if (out_fire)
        drain_ptr <= drain_ptr == LAST ? '0 : drain_ptr + ONE;
    end
  end
endmodule

// File: doc/sort_ctrl_2bit.md
Name: sort_ctrl_2bit

Overview:
- Sequencing controller that time-shares one external 2-bit magnitude comparator to sort a small buffer of 2-bit values in ascending order.
- Accepts DEPTH operands over a valid/ready input stream and runs bubble sort, one compare-and-swap per cycle, through the comparator port pair.
- Streams the sorted values out over valid/ready.
- Sits between an operand producer and the consumer of ordered data; the comparator itself stays outside this block.

Parameters:
- DEPTH, 4, number of 2-bit entries per sort job; legal range 2..8.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  producer has in_data
- in_data  input  2  operand to load
- in_ready  output  1  block accepts in_data this cycle
- out_valid  output  1  out_data holds a sorted entry
- out_data  output  2  sorted entry, smallest first
- out_ready  input  1  consumer takes out_data this cycle
- cmp_a  output  2  operand A to the shared comparator
- cmp_b  output  2  operand B to the shared comparator
- cmp_y  input  3  comparator result, one-hot: 001 a==b, 010 a<b, 100 a>b
- busy  output  1  high in SORT state
- cmp_err  output  1  sticky: an illegal cmp_y was sampled during SORT

Behaviour:
- Clock and reset: one clock, clk; rst is synchronous and active-high.
- Reset, effective at the clk edge with rst=1:
  - state=LOAD, load/drain pointers=0, pass/index counters=0.
  - cmp_err=0 and buffer cleared to 0.
  - Outputs after that edge: in_ready=1, out_valid=0, busy=0, cmp_a=cmp_b=0.
- Reset mid-operation (any state) discards the buffer and the job.
- States: LOAD, SORT, DRAIN.
- LOAD:
  - in_ready=1.
  - Each in_valid&&in_ready edge writes buf[load_ptr] and increments load_ptr.
  - On the DEPTH-th accept: go to SORT, in_ready=0 from the next cycle, pass=0, idx=0.
- SORT:
  - busy=1. cmp_a=buf[idx], cmp_b=buf[idx+1], combinational from registered idx; cmp_y is sampled the same cycle.
  - cmp_y=100: swap buf[idx] and buf[idx+1] at the clock edge.
  - cmp_y=001 or 010: no swap (equal values are never swapped, so the sort is stable).
  - Any other cmp_y: no swap, and cmp_err is set and held until rst.
  - idx runs 0..DEPTH-2 within a pass, then wraps to 0 and pass increments.
  - After pass DEPTH-2 completes, go to DRAIN.
  - Total SORT cycles: (DEPTH-1)^2; 9 for DEPTH=4.
  - Outside SORT, cmp_a=cmp_b=0.
- DRAIN:
  - out_valid=1, out_data=buf[drain_ptr].
  - Each out_valid&&out_ready edge increments drain_ptr.
  - out_ready=0 holds out_data stable.
  - After the DEPTH-th handshake: drain_ptr=0, out_valid=0, and state returns to LOAD, with in_ready=1 the next cycle.
- No simultaneous input and output: in_ready and out_valid are never both 1.
- cmp_err does not stop sorting; the job completes with the unswapped data.
- No combinational path from in_valid to in_ready, or from out_ready to out_valid.

Optional Feature:
- Macro: SORT_EARLY_EXIT_EN.
- Defined:
  - A per-pass swap flag clears at idx=0.
  - If a pass ends with no swaps, SORT exits to DRAIN immediately; an already-sorted job takes DEPTH-1 SORT cycles.
  - The pass-count cap (DEPTH-1 passes) still applies.
- Undefined:
  - SORT always runs exactly (DEPTH-1)^2 cycles, regardless of data.

Test Plan:
- DEPTH=4, bench comparator model attached. Load 3,1,2,0 → busy high for exactly 9 cycles → out sequence 0,1,2,3, then in_ready=1 on the cycle after the 4th output handshake.
- Duplicates: load 2,2,1,1 → out 1,1,2,2. No swap on any cycle where cmp_y=001 (check via cmp_a/cmp_b trace). cmp_err=0.
- Backpressure: hold out_ready=0 for 5 cycles in DRAIN → out_valid=1, out_data=0 held constant. Toggling out_ready thereafter yields 0,1,2,3 with no drop or repeat.
- Reset mid-SORT: assert rst on the 4th SORT cycle → next cycle state LOAD, in_ready=1, out_valid=0, busy=0. A fresh load of 1,0,3,2 sorts to 0,1,2,3.
- Illegal comparator: force cmp_y=000 on the first SORT cycle of job 3,1,2,0 → cmp_err=1 from the next cycle and stays set until rst. The job still completes (9 cycles) and outputs 4 values.
- Early exit (SORT_EARLY_EXIT_EN defined): load 0,1,2,3 → busy high 3 cycles. With the macro undefined, the same stimulus gives 9 cycles. Both give out 0,1,2,3.
